// File: rtl/sd_sector_arbiter.sv
// sd_sector_arbiter: round-robin arbiter sharing one sd_card sector interface between two disk clients
module sd_sector_arbiter #(
  parameter int START_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  c_rd,
  input  logic [1:0]  c_wr,
  input  logic [31:0] c_lba0,
  input  logic [31:0] c_lba1,
  input  logic [7:0]  c_din0,
  input  logic [7:0]  c_din1,
  output logic [1:0]  c_ack,
  output logic [1:0]  c_done,
  output logic [1:0]  c_err,
  output logic [8:0]  c_buff_addr,
  output logic [7:0]  c_dout,
  output logic [1:0]  c_dout_strobe,
  output logic [1:0]  sd_rstart,
  output logic [1:0]  sd_wstart,
  output logic [31:0] sd_sector,
  input  logic        sd_rbusy,
  input  logic        sd_rdone,
  input  logic        sd_outen,
  input  logic [8:0]  sd_outaddr,
  input  logic [7:0]  sd_outbyte,
  output logic [7:0]  sd_inbyte
);
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
  state_t state;
  logic [1:0] rd_q, wr_q, pend_rd, pend_wr, pend_any, clr_rd, clr_wr, sel_bit, gnt_bit;
  logic gnt, last, busy_q, sel, sel_wr, grant;
  logic [12:0] cnt;
  always_comb begin
    pend_any = pend_rd | pend_wr;
    sel = pend_any[~last] ? ~last : last;
    sel_wr = ~pend_rd[sel];
    sel_bit = sel ? 2'b10 : 2'b01;
    gnt_bit = gnt ? 2'b10 : 2'b01;
    grant = state == IDLE && |pend_any;
    clr_rd = grant && !sel_wr ? sel_bit : 2'b00;
    clr_wr = grant && sel_wr ? sel_bit : 2'b00;
    c_dout = sd_outbyte;
    c_buff_addr = sd_outaddr;
    c_dout_strobe = sd_outen && (state == START || state == WAIT) ? gnt_bit : 2'b00;
    sd_inbyte = gnt ? c_din1 : c_din0;
  end
  // an edge landing in the grant cycle of the same bit is dropped by the clear mask
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rd_q <= 2'b00;
      wr_q <= 2'b00;
      pend_rd <= 2'b00;
      pend_wr <= 2'b00;
      gnt <= 1'b0;
      last <= 1'b1;
      busy_q <= 1'b0;
      cnt <= 13'd0;
      c_ack <= 2'b00;
      c_done <= 2'b00;
      c_err <= 2'b00;
      sd_rstart <= 2'b00;
      sd_wstart <= 2'b00;
      sd_sector <= 32'd0;
    end else begin
      rd_q <= c_rd;
      wr_q <= c_wr;
      busy_q <= sd_rbusy;
      pend_rd <= (pend_rd | (c_rd & ~rd_q)) & ~clr_rd;
      pend_wr <= (pend_wr | (c_wr & ~wr_q)) & ~clr_wr;
      c_done <= 2'b00;
      c_err <= 2'b00;
      case (state)
        IDLE: if (grant) begin
          gnt <= sel;
          sd_sector <= sel ? c_lba1 : c_lba0;
          sd_rstart <= sel_wr ? 2'b00 : sel_bit;
          sd_wstart <= sel_wr ? sel_bit : 2'b00;
          cnt <= 13'd0;
          state <= START;
        end
        START: if (sd_rbusy) begin
          sd_rstart <= 2'b00;
          sd_wstart <= 2'b00;
          c_ack <= gnt_bit;
          state <= WAIT;
        end else if (cnt == 13'(START_TIMEOUT - 1)) begin
          sd_rstart <= 2'b00;
          sd_wstart <= 2'b00;
          c_done <= gnt_bit;
          c_err <= gnt_bit;
          state <= IDLE;
        end else if (~&cnt) begin
          cnt <= cnt + 13'd1;
        end
        WAIT: if (sd_rdone || (busy_q && !sd_rbusy)) begin
          c_ack <= 2'b00;
          c_done <= gnt_bit;
          state <= DONE;
        end
        DONE: begin
          last <= gnt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_sector_arbiter.sv
// tb_sd_sector_arbiter: scoreboard bench with a round-robin queue model and a behavioural sd_card responder
module tb_sd_sector_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] c_rd = 2'b00, c_wr = 2'b00;
  logic [31:0] c_lba0 = 32'd0, c_lba1 = 32'd0;
  logic [7:0] c_din0, c_din1, c_dout, sd_inbyte, sd_outbyte;
  logic [1:0] c_ack, c_done, c_err, c_dout_strobe, sd_rstart, sd_wstart;
  logic [8:0] c_buff_addr, sd_outaddr;
  logic [31:0] sd_sector;
  logic sd_rbusy = 1'b0, sd_rdone = 1'b0, sd_outen;

  typedef struct {int client; bit wr; logic [31:0] sector; bit err;} txn_t;
  txn_t exp_q[$];
  txn_t cur, e;
  int n_cmp = 0, n_bad = 0, n_done = 0, n_starts = 0, stb0 = 0, stb1 = 0;
  bit in_txn = 1'b0, m_last = 1'b1;
  bit sd_mode = 1'b0, sd_rand = 1'b1, sd_kill = 1'b0;
  int sd_len = 8, sd_tail = 0;
  logic [1:0] st, prev_st = 2'b00;
  logic [7:0] e_in;

  // clients answer writes with a byte derived from the address they are shown
  assign c_din1 = c_buff_addr[7:0];
  assign c_din0 = ~c_buff_addr[7:0];

  sd_sector_arbiter dut (
    .clk(clk), .reset(reset), .c_rd(c_rd), .c_wr(c_wr), .c_lba0(c_lba0), .c_lba1(c_lba1),
    .c_din0(c_din0), .c_din1(c_din1), .c_ack(c_ack), .c_done(c_done), .c_err(c_err),
    .c_buff_addr(c_buff_addr), .c_dout(c_dout), .c_dout_strobe(c_dout_strobe),
    .sd_rstart(sd_rstart), .sd_wstart(sd_wstart), .sd_sector(sd_sector), .sd_rbusy(sd_rbusy),
    .sd_rdone(sd_rdone), .sd_outen(sd_outen), .sd_outaddr(sd_outaddr), .sd_outbyte(sd_outbyte),
    .sd_inbyte(sd_inbyte)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int c);
    return c != 0 ? 2'b10 : 2'b01;
  endfunction

  // reference: serve the other client if it has work, reads before writes, last follows each completion
  task automatic model_batch(input logic [1:0] r, input logic [1:0] w);
    logic [1:0] pr, pw;
    int other, sel;
    bit wr;
    pr = r;
    pw = w;
    while ((pr | pw) != 2'b00) begin
      other = m_last ? 0 : 1;
      sel = (pr[other] || pw[other]) ? other : (m_last ? 1 : 0);
      wr = !pr[sel];
      if (wr) pw[sel] = 1'b0;
      else pr[sel] = 1'b0;
      exp_q.push_back('{sel, wr, sel != 0 ? c_lba1 : c_lba0, 1'b0});
      m_last = sel != 0;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_txn) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    if (exp_q.size() != 0) begin
      exp_q.delete();
      in_txn = 1'b0;
    end
    repeat (2) tick();
  endtask

  task automatic sd_serve();
    int len, tail;
    len = sd_rand ? int'($urandom_range(1, 16)) : sd_len;
    tail = sd_rand ? int'($urandom_range(0, 3)) : sd_tail;
    repeat ($urandom_range(0, 3)) tick();
    sd_rbusy = 1'b1;
    for (int i = 0; i < len && !sd_kill; i++) begin
      tick();
      sd_outen = 1'b1;
      sd_outaddr = 9'(i);
      sd_outbyte = 8'($urandom);
    end
    tick();
    sd_outen = 1'b0;
    for (int i = 0; i < tail && !sd_kill; i++) tick();
    if (!sd_kill && $urandom_range(0, 1) == 1) begin
      sd_rdone = 1'b1;
      tick();
      sd_rdone = 1'b0;
    end
    sd_rbusy = 1'b0;
  endtask

  initial begin
    sd_outen = 1'b1;
    sd_outaddr = 9'h1A5;
    sd_outbyte = 8'h3C;
    wait (reset == 1'b0);
    sd_outen = 1'b0;
    sd_outaddr = 9'd0;
    forever begin
      tick();
      if (!sd_mode && !sd_kill && (sd_rstart | sd_wstart) != 2'b00) sd_serve();
    end
  end

  always @(negedge clk) begin
    st = sd_rstart | sd_wstart;
    stb0 += int'(c_dout_strobe[0]);
    stb1 += int'(c_dout_strobe[1]);
    if (!reset) begin
      if (st != 2'b00 && prev_st == 2'b00) begin
        n_starts++;
        if (exp_q.size() == 0) chk("unexpected_start", st, 2'b00);
        else begin
          cur = exp_q[0];
          in_txn = 1'b1;
          chk("rstart", sd_rstart, cur.wr ? 2'b00 : oh(cur.client));
          chk("wstart", sd_wstart, cur.wr ? oh(cur.client) : 2'b00);
          chk("sector", sd_sector, cur.sector);
        end
      end
      if (sd_outen && in_txn) begin
        e_in = cur.client != 0 ? sd_outaddr[7:0] : ~sd_outaddr[7:0];
        chk("strobe", c_dout_strobe, oh(cur.client));
        chk("inbyte", sd_inbyte, e_in);
      end
      if (c_done != 2'b00) begin
        n_done++;
        if (exp_q.size() == 0) chk("unexpected_done", c_done, 2'b00);
        else begin
          e = exp_q.pop_front();
          chk("done_client", c_done, oh(e.client));
          chk("err", c_err, e.err ? oh(e.client) : 2'b00);
          in_txn = 1'b0;
        end
      end else if (c_err != 2'b00) chk("err_without_done", c_err, 2'b00);
    end
    prev_st = st;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int s0, s1, d0, st0, n;
    logic [1:0] r, w;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_ack", c_ack, 2'b00);
    chk("rst_done", c_done, 2'b00);
    chk("rst_err", c_err, 2'b00);
    chk("rst_rstart", sd_rstart, 2'b00);
    chk("rst_wstart", sd_wstart, 2'b00);
    chk("rst_sector", sd_sector, 32'd0);
    chk("rst_strobe", c_dout_strobe, 2'b00);
    chk("rst_dout", c_dout, 8'h3C);
    chk("rst_addr", c_buff_addr, 9'h1A5);
    tick();
    reset = 1'b0;
    tick();
    sd_rand = 1'b1;
    repeat (2) begin
      c_lba0 = $urandom;
      c_lba1 = $urandom;
      model_batch(2'b11, 2'b00);
      c_rd = 2'b11;
      repeat (2) tick();
      c_rd = 2'b00;
      drain(500);
    end
    sd_rand = 1'b0;
    sd_len = 512;
    sd_tail = 88;
    s0 = stb0;
    s1 = stb1;
    d0 = n_done;
    c_lba0 = 32'h5A;
    model_batch(2'b01, 2'b00);
    c_rd = 2'b01;
    repeat (2) @(negedge clk);
    chk("latency_plus1", sd_rstart, 2'b00);
    @(negedge clk);
    chk("latency_plus2", sd_rstart, 2'b01);
    tick();
    c_rd = 2'b00;
    drain(2000);
    chk("read_stb0", stb0 - s0, 512);
    chk("read_stb1", stb1 - s1, 0);
    chk("read_done", n_done - d0, 1);
    sd_rand = 1'b1;
    d0 = n_done;
    st0 = n_starts;
    c_lba0 = $urandom;
    model_batch(2'b01, 2'b00);
    c_rd = 2'b01;
    repeat (3000) tick();
    c_rd = 2'b00;
    drain(100);
    chk("held_starts", n_starts - st0, 1);
    chk("held_done", n_done - d0, 1);
    sd_rand = 1'b0;
    sd_tail = 20;
    s0 = stb0;
    s1 = stb1;
    c_lba1 = $urandom;
    model_batch(2'b00, 2'b10);
    c_wr = 2'b10;
    repeat (2) tick();
    c_wr = 2'b00;
    drain(2000);
    chk("write_stb1", stb1 - s1, 512);
    chk("write_stb0", stb0 - s0, 0);
    sd_rand = 1'b1;
    for (int b = 0; b < 40; b++) begin
      r = 2'($urandom);
      w = 2'($urandom);
      if ((r | w) == 2'b00) r = 2'b10;
      c_lba0 = $urandom;
      c_lba1 = $urandom;
      model_batch(r, w);
      c_rd = r;
      c_wr = w;
      repeat ($urandom_range(1, 4)) tick();
      c_rd = 2'b00;
      c_wr = 2'b00;
      drain(1000);
    end
    sd_mode = 1'b1;
    tick();
    c_lba0 = $urandom;
    exp_q.push_back('{0, 1'b0, c_lba0, 1'b1});
    c_rd = 2'b01;
    n = 0;
    while (sd_rstart == 2'b00 && n < 10) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (c_done == 2'b00 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, 4096);
    chk("timeout_err", c_err, 2'b01);
    tick();
    c_rd = 2'b00;
    sd_mode = 1'b0;
    drain(10);
    d0 = n_done;
    c_lba0 = $urandom;
    model_batch(2'b01, 2'b00);
    c_rd = 2'b01;
    repeat (2) tick();
    c_rd = 2'b00;
    drain(500);
    chk("after_timeout_done", n_done - d0, 1);
    sd_rand = 1'b0;
    sd_len = 200;
    sd_tail = 10;
    c_lba0 = $urandom;
    model_batch(2'b01, 2'b00);
    c_rd = 2'b01;
    n = 0;
    while (c_ack[0] == 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ack", c_ack, 2'b01);
    repeat (10) tick();
    c_rd = 2'b11;
    repeat (3) tick();
    reset = 1'b1;
    c_rd = 2'b00;
    sd_kill = 1'b1;
    exp_q.delete();
    in_txn = 1'b0;
    m_last = 1'b1;
    d0 = n_done;
    st0 = n_starts;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_ack", c_ack, 2'b00);
    chk("mid_rst_done", c_done, 2'b00);
    chk("mid_rst_err", c_err, 2'b00);
    chk("mid_rst_rstart", sd_rstart, 2'b00);
    chk("mid_rst_wstart", sd_wstart, 2'b00);
    chk("mid_rst_sector", sd_sector, 32'd0);
    chk("mid_rst_strobe", c_dout_strobe, 2'b00);
    tick();
    reset = 1'b0;
    repeat (20) tick();
    sd_kill = 1'b0;
    repeat (60) tick();
    chk("mid_rst_no_done", n_done - d0, 0);
    chk("mid_rst_no_start", n_starts - st0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sd_sector_arbiter.md
# sd_sector_arbiter

Arbitrates sector read/write requests from two storage clients (client 0: fdc1772 floppy, client 1: ACSI hard disk) onto the single command/data interface of `sd_card`. It serialises transactions with round-robin priority. It forwards `sd_card` byte traffic only to the granted client and muxes that client's write data back into `sd_card`. It sits between the disk controllers and `sd_card`, in place of the direct `sd_rd`/`sd_wr`/`sd_ack` wiring.

## Interface
- `START_TIMEOUT`, default 4096: number of cycles allowed for `sd_rbusy` to rise after a start is issued.
- `clk` in 1: system clock (32 MHz).
- `reset` in 1: synchronous, active-high.
- `c_rd` in 2: per-client read request, level, one bit per client.
- `c_wr` in 2: per-client write request, level.
- `c_lba0`, `c_lba1` in 32: sector address of client 0 and client 1.
- `c_din0`, `c_din1` in 8: write data from client 0 and client 1.
- `c_ack` out 2: per-client busy/acknowledge, equivalent to `sd_ack`.
- `c_done` out 2: one-cycle end-of-transaction pulse.
- `c_err` out 2: one-cycle pulse on start timeout, coincident with `c_done`.
- `c_buff_addr` out 9: byte index within the sector, broadcast to both clients.
- `c_dout` out 8: read byte, broadcast to both clients.
- `c_dout_strobe` out 2: per-client byte strobe; only the granted client's bit can be high.
- `sd_rstart` out 2: read start to `sd_card`; bit i serves client i.
- `sd_wstart` out 2: write start to `sd_card`.
- `sd_sector` out 32: LBA of the granted transaction.
- `sd_rbusy` in 1: `sd_card` busy.
- `sd_rdone` in 1: `sd_card` done pulse.
- `sd_outen` in 1: `sd_card` byte strobe.
- `sd_outaddr` in 9: `sd_card` byte index.
- `sd_outbyte` in 8: `sd_card` read byte.
- `sd_inbyte` out 8: write data to `sd_card`.

## Operation
- **Request capture.** Requests are edge-triggered. A registered copy of `c_rd` and `c_wr` detects rising edges. Each rising edge sets the matching bit in `pend_rd[1:0]` or `pend_wr[1:0]`.
  - A request held high across transactions never re-triggers.
- **Same-client conflict.** If one client has both read and write pending, the read is served first and the write stays pending.
- **Pending clear.** A pending bit clears in the cycle its grant is issued. An edge arriving in that same cycle for the same bit is lost; clients must deassert between requests.
- **Arbitration.** `last` is a 1-bit register holding the last served client; it resets to 1, so client 0 wins first. The client other than `last` wins if it has anything pending. Otherwise, the pending client is granted.
- **FSM states:** IDLE, START, WAIT, DONE.
  - **IDLE:** if any bit is pending, latch `gnt`, `op` (read/write) and `sd_sector` from the selected client's LBA. Then clear that pending bit and go to START.
  - **START:** assert `sd_rstart[gnt]` or `sd_wstart[gnt]` and hold it until `sd_rbusy` = 1.
    - Set `c_ack[gnt]` = 1 when `sd_rbusy` is seen, then go to WAIT.
    - If a counter reaches `START_TIMEOUT` without `sd_rbusy`: drop start, pulse `c_done[gnt]` and `c_err[gnt]`, then go to IDLE.
  - **WAIT:** `c_ack[gnt]` stays 1. Exit to DONE on `sd_rdone` = 1 or on a falling edge of `sd_rbusy`, whichever comes first.
  - **DONE:** `c_ack` = 0. Pulse `c_done[gnt]` for one cycle, set `last` ← `gnt`, then go to IDLE.
- **Data routing (combinational from registered `gnt`):**
  - `c_dout` = `sd_outbyte`; `c_buff_addr` = `sd_outaddr`.
  - `c_dout_strobe[gnt]` = `sd_outen` in START/WAIT; the other strobe bit is 0.
  - `sd_inbyte` = `gnt` ? `c_din1` : `c_din0`.

## Timing
- **Reset values:**
  - FSM = IDLE; `pend_*` = 0; `gnt` = 0; `last` = 1.
  - All start, ack, done, err and strobe bits = 0.
  - `sd_sector` = 0; `c_dout` and `c_buff_addr` follow their inputs.
- **Reset mid-transaction:** starts and acks drop in the next cycle and no `c_done` is issued.
- **Latency:** a rising edge of `c_rd` at cycle N is pending at N+1, reaches IDLE→START at N+1, and `sd_rstart` is high at N+2 (registered).
- **Ack:** `c_ack` rises one cycle after `sd_rbusy` is first sampled high.
- **Done:** `c_done` fires exactly one cycle after the WAIT exit condition.
- **Back-to-back:** a new grant is possible in the cycle after DONE. Minimum idle gap between transactions is 1 cycle.
- **Timeout counter:** 13 bits, saturating, cleared on every entry to START.
- **Pass-through:** `sd_outen` to `c_dout_strobe` is combinational with zero latency, so client byte capture timing equals the direct `sd_card` connection.

## Test plan
- **Single floppy read:** `c_rd[0]` rises with LBA 0x5A, `sd_card` model busy for 600 cycles with 512 strobes.
  - `sd_rstart` = 01 at +2, `sd_sector` = 0x5A.
  - Exactly 512 `c_dout_strobe[0]` and zero `c_dout_strobe[1]`.
  - One `c_done[0]`.
- **Simultaneous requests:** `c_rd` = 11 in the same cycle after reset.
  - Client 0 is served first, then client 1.
  - A second simultaneous pair is served as 0, then 1 again (alternation verified via `last`).
- **Held request:** `c_rd[0]` is held high for 3000 cycles. Exactly one transaction results.
- **Write path:** `c_wr[1]` with `c_din1` = address LSB. `sd_wstart` = 10 and `sd_inbyte` tracks `c_din1` across all 512 addresses.
- **Timeout:** model never raises busy.
  - `c_done[0]` and `c_err[0]` pulse together 4096 cycles after start.
  - FSM returns to IDLE and the next request is served normally.
- **Reset during WAIT:** all outputs go to reset values the next cycle, no `c_done` is issued, and pending requests are cleared.
